sram_scan_master: RTL and testbench
===================================

# sram_scan_master

Serial scan master that drives the SRAM scan test port from a parallel command interface. It accepts one command of address, word count and direction. It resets the scan target, shifts out the address/count header, then either streams write words out or captures read words returned on the target's scan output. It sits between the on-chip test controller (or a UART command decoder) and the SRAM scan wrapper.

## Interface
- N_addr, 11, address bits in header
- N_cnt, 12, count field bits in header; bit 0 is the mode flag and bits [N_cnt-1:1] hold the count
- N_data, 8, data word width
- RST_CYC, 2, cycles scan_rst_n is held low at transaction start (≥1)
- WORD_SLOT, 18, clk_1 cycles per data word slot (≥ RD_OFS+N_data, ≥ N_data)
- RD_OFS, 9, slot cycle index of the first read data bit on scan_so
- clk_1  in  1  clock; all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write transaction, 0 = read
- cmd_addr  in  N_addr  base address
- cmd_len  in  N_cnt-1  words transferred minus one
- wr_data  in  N_data  next write word
- wr_valid  in  1  wr_data valid
- wr_ready  out  1  one-cycle pulse at slot cycle 0 of each write slot; the word is consumed if wr_valid is high
- rd_data  out  N_data  captured read word
- rd_valid  out  1  one-cycle pulse; no backpressure
- scan_rst_n  out  1  drives target reset
- scan_si  out  1  serial data to target scan input
- scan_so  in  1  serial data from target scan output
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at transaction end
- err_underrun  out  1  sticky; cleared on command accept

## Operation
- States: IDLE → RST → HDR → DATA → DONE → IDLE.
- IDLE: cmd_ready=1. On cmd_valid, register all cmd_* fields, clear err_underrun, and go to RST.
- RST: scan_rst_n=0 and scan_si=0 for RST_CYC cycles, then go to HDR.
- HDR: header H = {cmd_addr, cmd_len, cmd_write}, width N_addr+N_cnt.
  - Shifted LSB first, one bit per cycle: H[0] (mode) first, the address MSB last.
  - After N_addr+N_cnt cycles, go to DATA.
- DATA: cmd_len+1 slots of WORD_SLOT cycles each, with a slot cycle counter s = 0..WORD_SLOT-1 and a word counter.
- Write slot:
  - At s=0, load a shift register with wr_data if wr_valid, otherwise load 0 and set err_underrun.
  - For s=0..N_data-1, scan_si = word bit s, LSB first.
  - For all other s, scan_si = 0.
- Read slot:
  - scan_si=0 throughout.
  - For s=RD_OFS..RD_OFS+N_data-1, sample scan_so into rd bit (s-RD_OFS), LSB first.
  - On the cycle after the last sample, rd_data updates and rd_valid pulses.
- After the final slot, go to DONE: done=1 for one cycle, then IDLE.
- scan_rst_n stays 1 after a transaction until the next command's RST state.
- Counter widths:
  - Word counter is N_cnt-1 bits and compares equal to the registered cmd_len. No wrap: cmd_len = all-ones gives 2^(N_cnt-1) words.
  - Header bit counter is sized for N_addr+N_cnt.
  - Slot counter is sized for WORD_SLOT.
- cmd_valid outside IDLE is ignored; the command is not queued.
- The command registers are frozen while busy.

## Timing
- Reset values: cmd_ready=1, busy=0, done=0, rd_valid=0, rd_data=0, wr_ready=0, err_underrun=0, scan_si=0, scan_rst_n=0. The target is held in reset until the first command completes its RST state.
- Reset is asynchronous at any point, including mid-header or mid-data. The FSM returns to IDLE with all outputs at their reset values, no done pulse is issued, and partial read data is discarded.
- Let accept = cycle 0, with N_addr+N_cnt written as H below.
  - scan_rst_n=0 on cycles 1..RST_CYC.
  - Header bit k is on scan_si during cycle 1+RST_CYC+k.
  - Slot j, cycle s, occurs at cycle 1+RST_CYC+H+j·WORD_SLOT+s.
  - done is at cycle 1+RST_CYC+H+(cmd_len+1)·WORD_SLOT.
  - cmd_ready returns 1 on the next cycle.
- All outputs are registered and update on posedge clk_1. The target samples scan_si on negedge.
- wr_ready and the wr_data sample occur in the same cycle (s=0). A word presented later than that misses the slot.
- rd_valid for slot j fires at slot cycle RD_OFS+N_data. If that exceeds WORD_SLOT-1, it fires at cycle 0 of the next slot, or in the DONE cycle for the last slot.

## Test plan
- Reset: hold rst_n=0, then release → scan_rst_n=0, cmd_ready=1, busy=0, scan_si=0, and no pulses on done, rd_valid or wr_ready.
- Single write: addr=0x005, len=0, write, wr_data=0xA5 held valid.
  - Header bits 0..22 = 1,0×11,1,0,1,0×8.
  - Slot bits = 1,0,1,0,0,1,0,1.
  - done at cycle 1+2+23+18 = 44, err_underrun=0.
- Burst write: len=2, words 0x11/0x22/0x33 → three wr_ready pulses 18 cycles apart, with serialized words matching LSB first.
- Read: addr=0x7FF, len=1.
  - A bench model drives 0x3C and then 0xC3 on scan_so, starting at slot cycle 9.
  - rd_valid pulses twice, with rd_data=0x3C then 0xC3.
  - Header mode bit is 0.
- Underrun: write with len=1 and wr_valid low at the second slot's s=0 → second word is serialized as 0x00, err_underrun=1 until the next accept.
- Reset mid-op: assert rst_n low during header bit 10 → immediate return to reset values. A following command completes normally with correct timing.

Source files
------------

// File: rtl/sram_scan_master.sv
// SRAM scan-port master: takes one parallel command and runs a reset, header
// and data-slot sequence on the serial scan pins of the SRAM scan wrapper.
//
// state  | meaning
// S_IDLE | waiting for a command, cmd_ready high
// S_RST  | scan target held in reset for RST_CYC cycles
// S_HDR  | header {addr, len, mode} shifted out LSB first
// S_DATA | cmd_len+1 word slots of WORD_SLOT cycles each
// S_DONE | one-cycle done pulse, then back to idle
//
// All outputs are flops loaded from next-state values, so the pins show the
// current state's behaviour in the same cycle the state register does. For
// that reason wr_data is captured on the clock edge that opens slot cycle 0
// (the same edge that raises wr_ready), letting bit 0 reach scan_si at s=0.
module sram_scan_master #(
  parameter int N_addr    = 11,
  parameter int N_cnt     = 12,
  parameter int N_data    = 8,
  parameter int RST_CYC   = 2,
  parameter int WORD_SLOT = 18,
  parameter int RD_OFS    = 9
) (
  input  logic              clk_1,
  input  logic              rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [N_addr-1:0] i_cmd_addr,
  input  logic [N_cnt-2:0]  i_cmd_len,
  input  logic [N_data-1:0] i_wr_data,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  output logic [N_data-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_scan_rst_n,
  output logic              o_scan_si,
  input  logic              i_scan_so,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_underrun
);

  localparam int H       = N_addr + N_cnt;
  localparam int CNT_MAX = (H > RST_CYC) ? H : RST_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int SW      = (WORD_SLOT > 1) ? $clog2(WORD_SLOT) : 1;
  localparam int WW      = N_cnt - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_HDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [SW-1:0]     r_slot;
  logic [SW-1:0]     w_slot_nxt;
  logic [WW-1:0]     r_word;
  logic [WW-1:0]     w_word_nxt;

  logic [WW-1:0]     r_len;
  logic              r_write;
  logic [H-1:0]      r_hsh;
  logic [N_data-2:0] r_wsh;
  logic [N_data-2:0] r_rsh;

  logic              w_accept;
  logic              w_hdr_shift;
  logic              w_wr_start;
  logic              w_wr_shift;
  logic              w_si_nxt;
  logic [N_data-1:0] w_word_in;
  logic              w_rd_sample;
  logic              w_rd_last;

  assign w_accept    = (r_state == S_IDLE) && i_cmd_valid;
  assign w_word_in   = i_wr_valid ? i_wr_data : '0;
  assign w_rd_sample = (r_state == S_DATA) && !r_write &&
                       (int'(r_slot) >= RD_OFS) && (int'(r_slot) < RD_OFS + N_data);
  assign w_rd_last   = w_rd_sample && (int'(r_slot) == RD_OFS + N_data - 1);

  // State and counter registers
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_slot  <= '0;
      r_word  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_slot  <= w_slot_nxt;
      r_word  <= w_word_nxt;
    end
  end

  // Next-state and counter sequencing
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_slot_nxt  = r_slot;
    w_word_nxt  = r_word;
    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          w_state_nxt = S_RST;
          w_cnt_nxt   = '0;
        end
      end
      S_RST: begin
        if (r_cnt == CW'(RST_CYC - 1)) begin
          w_state_nxt = S_HDR;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_HDR: begin
        if (r_cnt == CW'(H - 1)) begin
          w_state_nxt = S_DATA;
          w_slot_nxt  = '0;
          w_word_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_slot == SW'(WORD_SLOT - 1)) begin
          w_slot_nxt = '0;
          if (r_word == r_len) begin
            w_state_nxt = S_DONE;
          end else begin
            w_word_nxt = r_word + 1'b1;
          end
        end else begin
          w_slot_nxt = r_slot + 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next scan_si value and shift-register strobes for the upcoming cycle
  always_comb begin
    w_si_nxt    = 1'b0;
    w_hdr_shift = 1'b0;
    w_wr_start  = 1'b0;
    w_wr_shift  = 1'b0;
    if (w_state_nxt == S_HDR) begin
      if (w_cnt_nxt == '0) begin
        w_si_nxt = r_hsh[0];
      end else begin
        w_si_nxt    = r_hsh[1];
        w_hdr_shift = 1'b1;
      end
    end else if ((w_state_nxt == S_DATA) && r_write) begin
      if (w_slot_nxt == '0) begin
        w_wr_start = 1'b1;
        w_si_nxt   = w_word_in[0];
      end else if (int'(w_slot_nxt) < N_data) begin
        w_si_nxt   = r_wsh[0];
        w_wr_shift = 1'b1;
      end
    end
  end

  // Command capture on accept; header copy shifts out during S_HDR
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      r_len   <= '0;
      r_write <= 1'b0;
      r_hsh   <= '0;
    end else if (w_accept) begin
      r_len   <= i_cmd_len;
      r_write <= i_cmd_write;
      r_hsh   <= {i_cmd_addr, i_cmd_len, i_cmd_write};
    end else if (w_hdr_shift) begin
      r_hsh <= r_hsh >> 1;
    end
  end

  // Write word load/shift, wr_ready pulse and sticky underrun flag
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      r_wsh          <= '0;
      o_wr_ready     <= 1'b0;
      o_err_underrun <= 1'b0;
    end else begin
      o_wr_ready <= w_wr_start;
      if (w_accept) begin
        o_err_underrun <= 1'b0;
      end else if (w_wr_start && !i_wr_valid) begin
        o_err_underrun <= 1'b1;
      end
      if (w_wr_start) begin
        r_wsh <= w_word_in[N_data-1:1];
      end else if (w_wr_shift) begin
        r_wsh <= r_wsh >> 1;
      end
    end
  end

  // Read capture from scan_so, LSB first, publishing the word after the last bit
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      r_rsh      <= '0;
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= w_rd_last;
      if (w_rd_sample) begin
        r_rsh <= {i_scan_so, r_rsh[N_data-2:1]};
      end
      if (w_rd_last) begin
        o_rd_data <= {i_scan_so, r_rsh};
      end
    end
  end

  // Handshake, status and scan pin flops
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      o_cmd_ready  <= 1'b1;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_scan_si    <= 1'b0;
      o_scan_rst_n <= 1'b0;
    end else begin
      o_cmd_ready <= (w_state_nxt == S_IDLE);
      o_busy      <= (w_state_nxt != S_IDLE);
      o_done      <= (w_state_nxt == S_DONE);
      o_scan_si   <= w_si_nxt;
      if (w_state_nxt == S_RST) begin
        o_scan_rst_n <= 1'b0;
      end else if (r_state == S_RST) begin
        o_scan_rst_n <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_scan_master.sv
// Directed bench for sram_scan_master: reset, single/burst write, read,
// underrun and mid-header reset, with hand-computed headers and timings.
module tb_sram_scan_master;

  logic        clk_1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        i_cmd_write = 1'b0;
  logic [10:0] i_cmd_addr = '0;
  logic [10:0] i_cmd_len = '0;
  logic [7:0]  i_wr_data = '0;
  logic        i_wr_valid = 1'b0;
  logic        i_scan_so = 1'b0;
  logic        o_cmd_ready;
  logic        o_wr_ready;
  logic [7:0]  o_rd_data;
  logic        o_rd_valid;
  logic        o_scan_rst_n;
  logic        o_scan_si;
  logic        o_busy;
  logic        o_done;
  logic        o_err_underrun;

  int total = 0;
  int bad   = 0;

  logic [7:0] tb_words[4];
  logic       tb_wval[4];
  logic [7:0] tb_wexp[4];
  logic [7:0] tb_rd[4];

  sram_scan_master dut (
    .clk_1          (clk_1),
    .rst_n          (rst_n),
    .i_cmd_valid    (i_cmd_valid),
    .o_cmd_ready    (o_cmd_ready),
    .i_cmd_write    (i_cmd_write),
    .i_cmd_addr     (i_cmd_addr),
    .i_cmd_len      (i_cmd_len),
    .i_wr_data      (i_wr_data),
    .i_wr_valid     (i_wr_valid),
    .o_wr_ready     (o_wr_ready),
    .o_rd_data      (o_rd_data),
    .o_rd_valid     (o_rd_valid),
    .o_scan_rst_n   (o_scan_rst_n),
    .o_scan_si      (o_scan_si),
    .i_scan_so      (i_scan_so),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err_underrun (o_err_underrun)
  );

  always #5 clk_1 = ~clk_1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 32'(o_cmd_ready), 32'd1);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_done"}, 32'(o_done), 32'd0);
    chk({tag, "_rd_valid"}, 32'(o_rd_valid), 32'd0);
    chk({tag, "_rd_data"}, 32'(o_rd_data), 32'd0);
    chk({tag, "_wr_ready"}, 32'(o_wr_ready), 32'd0);
    chk({tag, "_err"}, 32'(o_err_underrun), 32'd0);
    chk({tag, "_scan_si"}, 32'(o_scan_si), 32'd0);
    chk({tag, "_scan_rst_n"}, 32'(o_scan_rst_n), 32'd0);
  endtask

  // Cycle numbering: accept cycle = 0, header bit k at 3+k, slot j cycle s at
  // 26+18j+s, read word j valid at 43+18j, done at 26+18(len+1).
  task automatic run_cmd(input logic wr, input logic [10:0] addr, input logic [10:0] len,
                         input logic [22:0] hdr_exp, input int done_exp, input logic err_exp,
                         input int abort_at);
    logic [22:0] hdr_got;
    logic [7:0]  wgot[4];
    logic [7:0]  rgot[4];
    int n_wr, n_rd, n_done, done_at;
    int bad_rst, bad_si, bad_wrr, bad_rdv, bad_busy;
    int s, j;
    hdr_got = 'x;
    wgot = '{default: 8'hxx};
    rgot = '{default: 8'hxx};
    n_wr = 0; n_rd = 0; n_done = 0; done_at = -1;
    bad_rst = 0; bad_si = 0; bad_wrr = 0; bad_rdv = 0; bad_busy = 0;

    @(negedge clk_1);
    i_cmd_write = wr;
    i_cmd_addr  = addr;
    i_cmd_len   = len;
    i_cmd_valid = 1'b1;
    chk("ready_before_accept", 32'(o_cmd_ready), 32'd1);
    @(negedge clk_1);
    i_cmd_valid = 1'b0;
    chk("err_cleared_on_accept", 32'(o_err_underrun), 32'd0);

    for (int t = 1; t <= done_exp + 1; t++) begin
      if (t == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        @(negedge clk_1);
        rst_n = 1'b1;
        i_wr_valid = 1'b0;
        i_scan_so  = 1'b0;
        return;
      end
      // inputs for the coming edge: write words change mid-slot, so_model per slot
      if (t >= 17 && (t - 17) % 18 == 0) begin
        j = (t - 17) / 18;
        if (j <= int'(len) && j < 4) begin
          i_wr_data  = tb_words[j];
          i_wr_valid = tb_wval[j];
        end
      end
      i_scan_so = 1'b0;
      if (t >= 26) begin
        s = (t - 26) % 18;
        j = (t - 26) / 18;
        if (!wr && j <= int'(len) && j < 4 && s >= 9 && s <= 16) i_scan_so = tb_rd[j][s-9];
      end
      // observe outputs of cycle t
      if (t <= 2) begin
        if (o_scan_rst_n !== 1'b0) bad_rst++;
        if (o_scan_si !== 1'b0) bad_si++;
      end else if (o_scan_rst_n !== 1'b1) begin
        bad_rst++;
      end
      if (t >= 3 && t <= 25) hdr_got[t-3] = o_scan_si;
      if (t >= 26 && t < done_exp) begin
        s = (t - 26) % 18;
        j = (t - 26) / 18;
        if (wr && s < 8 && j < 4) wgot[j][s] = o_scan_si;
        else if (o_scan_si !== 1'b0) bad_si++;
      end
      if (t >= done_exp && o_scan_si !== 1'b0) bad_si++;
      if (o_wr_ready === 1'b1) begin
        if (!(wr && t >= 26 && t < done_exp && (t - 26) % 18 == 0)) bad_wrr++;
        n_wr++;
      end
      if (o_rd_valid === 1'b1) begin
        if (t != 43 + 18 * n_rd) bad_rdv++;
        if (n_rd < 4) rgot[n_rd] = o_rd_data;
        n_rd++;
      end
      if (o_done === 1'b1) begin
        if (done_at < 0) done_at = t;
        n_done++;
      end
      if (o_busy !== (t <= done_exp)) bad_busy++;
      if (o_cmd_ready !== (t > done_exp)) bad_busy++;
      @(negedge clk_1);
    end
    i_wr_valid = 1'b0;

    chk("header", 32'(hdr_got), 32'(hdr_exp));
    chk("done_cycle", 32'(done_at), 32'(done_exp));
    chk("done_count", 32'(n_done), 32'd1);
    chk("wr_ready_count", 32'(n_wr), wr ? 32'(int'(len) + 1) : 32'd0);
    chk("wr_ready_timing", 32'(bad_wrr), 32'd0);
    chk("rd_valid_count", 32'(n_rd), wr ? 32'd0 : 32'(int'(len) + 1));
    chk("rd_valid_timing", 32'(bad_rdv), 32'd0);
    for (int k = 0; k <= int'(len) && k < 4; k++) begin
      if (wr) chk("wr_word_serial", 32'(wgot[k]), 32'(tb_wexp[k]));
      else    chk("rd_word", 32'(rgot[k]), 32'(tb_rd[k]));
    end
    chk("scan_rst_n_seq", 32'(bad_rst), 32'd0);
    chk("scan_si_quiet", 32'(bad_si), 32'd0);
    chk("busy_ready_seq", 32'(bad_busy), 32'd0);
    chk("err_underrun", 32'(o_err_underrun), 32'(err_exp));
  endtask

  initial begin
    tb_words = '{default: 8'h00};
    tb_wval  = '{default: 1'b0};
    tb_wexp  = '{default: 8'h00};
    tb_rd    = '{default: 8'h00};

    // reset held, then released: target stays in reset until first command
    repeat (3) @(negedge clk_1);
    chk_reset_vals("in_reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk_1);
    chk_reset_vals("after_reset");

    // single write 0xA5 to 0x005; header bits 1,0x11,1,0,1,0x8
    tb_words[0] = 8'hA5; tb_wval[0] = 1'b1; tb_wexp[0] = 8'hA5;
    run_cmd(1'b1, 11'h005, 11'd0, 23'h005001, 44, 1'b0, -1);
    repeat (4) @(negedge clk_1);
    chk("scan_rst_n_held_high", 32'(o_scan_rst_n), 32'd1);

    // burst write of three words
    tb_words[0] = 8'h11; tb_wval[0] = 1'b1; tb_wexp[0] = 8'h11;
    tb_words[1] = 8'h22; tb_wval[1] = 1'b1; tb_wexp[1] = 8'h22;
    tb_words[2] = 8'h33; tb_wval[2] = 1'b1; tb_wexp[2] = 8'h33;
    run_cmd(1'b1, 11'h123, 11'd2, 23'h123005, 80, 1'b0, -1);

    // read two words from 0x7FF; mode bit 0
    tb_wval = '{default: 1'b0};
    tb_rd[0] = 8'h3C; tb_rd[1] = 8'hC3;
    run_cmd(1'b0, 11'h7FF, 11'd1, 23'h7FF002, 62, 1'b0, -1);

    // underrun on second word
    tb_words[0] = 8'h96; tb_wval[0] = 1'b1; tb_wexp[0] = 8'h96;
    tb_words[1] = 8'hFF; tb_wval[1] = 1'b0; tb_wexp[1] = 8'h00;
    run_cmd(1'b1, 11'h040, 11'd1, 23'h040003, 62, 1'b1, -1);
    repeat (3) @(negedge clk_1);
    chk("err_sticky_in_idle", 32'(o_err_underrun), 32'd1);

    // reset during header bit 10 (a '1' bit), then a normal command
    tb_wval = '{default: 1'b0};
    run_cmd(1'b0, 11'h7FF, 11'h3FF, 23'h7FF7FE, 26 + 18 * 1024, 1'b0, 13);
    repeat (2) @(negedge clk_1);
    chk_reset_vals("post_abort_idle");
    tb_words[0] = 8'h5A; tb_wval[0] = 1'b1; tb_wexp[0] = 8'h5A;
    run_cmd(1'b1, 11'h2AA, 11'd0, 23'h2AA001, 44, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
